// File: rtl/if_prefetch.sv
// Instruction fetch stage: owns the fetch PC, issues one bus read at a time into a
// DEPTH-entry prefetch queue and presents {instr, pc} to decode; redirect flushes and restarts.
module if_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_req,
  input  logic [DATA_W-1:0] fetch_data,
  input  logic              fetch_ack
);

  localparam int unsigned       PTR_W        = $clog2(DEPTH);
  localparam int unsigned       CNT_W        = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK_C = ~(STEP_C - {{(ADDR_W-1){1'b0}}, 1'b1});

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              fetch_req_q, fetch_req_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [DATA_W-1:0] mem_instr_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc_q    [DEPTH];

  logic              pop_s;
  logic              push_s;
  logic [ADDR_W-1:0] redirect_pc_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic [CNT_W-1:0]  count_pop_s;

  assign pop_s         = out_valid_q & out_ready;
  assign redirect_pc_s = redirect_pc & ALIGN_MASK_C;
  assign next_pc_s     = fetch_pc_q + STEP_C;
  assign count_pop_s   = count_q - CNT_W'(pop_s);

  // Fetch control: request issue, completion handling and redirect tracking
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    fetch_req_d  = fetch_req_q;
    fetch_addr_d = fetch_addr_q;
    push_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_s;
        end else if (count_pop_s < DEPTH_C) begin
          state_d      = ST_BUSY;
          fetch_req_d  = 1'b1;
          fetch_addr_d = fetch_pc_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (fetch_ack && redirect) begin
          fetch_pc_d  = redirect_pc_s;
          state_d     = ST_IDLE;
          fetch_req_d = 1'b0;
        end else if (fetch_ack) begin
          push_s     = 1'b1;
          fetch_pc_d = next_pc_s;
          // Back-to-back fetch only if the pushed entry still leaves a free slot
          if ((count_pop_s + CNT_W'(1)) < DEPTH_C) begin
            fetch_addr_d = next_pc_s;
          end else begin
            state_d     = ST_IDLE;
            fetch_req_d = 1'b0;
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_pc_s;
          state_d    = ST_FLUSH;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (fetch_ack) begin
          state_d     = ST_IDLE;
          fetch_req_d = 1'b0;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        fetch_req_d = 1'b0;
      end
    endcase
  end

  // Queue pointers and the registered head view presented to decode
  always_comb begin
    out_valid_d = 1'b0;
    instr_d     = '0;
    pc_out_d    = '0;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      count_d  = count_pop_s + CNT_W'(push_s);
    end
    if (count_d == '0) begin
      out_valid_d = 1'b0;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      out_valid_d = 1'b1;
      instr_d     = fetch_data;
      pc_out_d    = fetch_addr_q;
    end else begin
      out_valid_d = 1'b1;
      instr_d     = mem_instr_q[rd_ptr_d];
      pc_out_d    = mem_pc_q[rd_ptr_d];
    end
  end

  // Control and output state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      instr_q      <= '0;
      pc_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
    end
  end

  // Queue storage; contents are only observed through count-qualified reads
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_instr_q[wr_ptr_q] <= fetch_data;
      mem_pc_q[wr_ptr_q]    <= fetch_addr_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign instr      = instr_q;
  assign pc_out     = pc_out_q;
  assign fetch_req  = fetch_req_q;
  assign fetch_addr = fetch_addr_q;

endmodule
